// File: rtl/run_detect_multi_pkg.sv
// Shared definitions for the multi-channel run-length detector:
// polarity mode encodings and the run qualification helper.
package run_detect_multi_pkg;

  localparam logic [1:0] MODE_ONES  = 2'b00;
  localparam logic [1:0] MODE_ZEROS = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  function automatic logic qual(input logic [1:0] mode, input logic b);
    logic q;
    case (mode)
      MODE_ONES:  q = b;
      MODE_ZEROS: q = ~b;
      MODE_BOTH:  q = 1'b1;
      default:    q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/run_detect_ch.sv
// One run-length detector channel: tracks the current run of identical bits,
// raises a level while qualified and a one-cycle pulse when the run first completes.
module run_detect_ch
  import run_detect_multi_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in,
  input  logic [1:0]       mode,
  output logic             out,
  output logic             pulse,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(RUN_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
    return (r == RUN_MAX) ? r : r + RUN_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             last_p1;
  logic [RUN_W-1:0] run_p1;
  logic             pulse_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic             vld_p0;
  logic             same_p0;
  logic             hit_p0;
  logic             run_we_p0;
  logic [RUN_W-1:0] run_nxt_p0;

  // Stage p0: qualify the incoming sample against registered run state.
  // run==0 means no history, so the first sample always starts a fresh run.
  assign vld_p0     = in_valid & ~clear;
  assign same_p0    = (run_p1 != '0) && (in == last_p1);
  assign run_nxt_p0 = same_p0 ? run_sat_inc(run_p1) : RUN_ONE;
  assign hit_p0     = vld_p0 && same_p0 && (run_p1 == RUN_PRE) && qual(mode, in);
  assign run_we_p0  = vld_p0 | clear;

  // Stage p1: run/last register, written only on an accepted sample or clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_p1  <= '0;
      last_p1 <= 1'b0;
    end else if (run_we_p0) begin
      if (clear) begin
        run_p1  <= '0;
        last_p1 <= 1'b0;
      end else begin
        run_p1  <= run_nxt_p0;
        last_p1 <= in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      pulse_p1 <= hit_p0;
      if (clear) begin
        cnt_p1 <= '0;
      end else if (hit_p0) begin
        cnt_p1 <= cnt_sat_inc(cnt_p1);
      end
    end
  end

  // Level output follows live mode, so a mode change shows up without a clock.
  assign out     = (run_p1 == RUN_MAX) & qual(mode, last_p1);
  assign pulse   = pulse_p1;
  assign hit_cnt = cnt_p1;

endmodule

// File: rtl/run_detect_multi.sv
// Multi-channel run-length detector: N_CH independent channels sharing mode
// and clear, with per-channel hit counters packed into one bus.
module run_detect_multi #(
  parameter int N_CH    = 4,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in,
  input  logic [1:0]            mode,
  output logic [N_CH-1:0]       out,
  output logic [N_CH-1:0]       pulse,
  output logic [N_CH*CNT_W-1:0] hit_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    run_detect_ch #(
      .RUN_LEN (RUN_LEN),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .in_valid (in_valid[i]),
      .in       (in[i]),
      .mode     (mode),
      .out      (out[i]),
      .pulse    (pulse[i]),
      .hit_cnt  (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_run_detect_multi.sv
// Scoreboard bench for run_detect_multi: directed rows push expected outputs,
// a monitor pops and compares one entry per clock. CNT_W=2 so saturation is reachable.
module tb_run_detect_multi;

  localparam int N_CH    = 4;
  localparam int RUN_LEN = 4;
  localparam int CNT_W   = 2;

  logic                  clk;
  logic                  rst;
  logic                  clear;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in;
  logic [1:0]            mode;
  logic [N_CH-1:0]       out;
  logic [N_CH-1:0]       pulse;
  logic [N_CH*CNT_W-1:0] hit_cnt;

  typedef struct {
    int                    id;
    logic [N_CH-1:0]       eo;
    logic [N_CH-1:0]       ep;
    logic [N_CH*CNT_W-1:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  run_detect_multi #(
    .N_CH    (N_CH),
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in       (in),
    .mode     (mode),
    .out      (out),
    .pulse    (pulse),
    .hit_cnt  (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
  endtask

  // Monitor: outputs are valid every cycle, sampled 2 ns after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out",     e.id, 8'(out),     8'(e.eo));
        chk("pulse",   e.id, 8'(pulse),   8'(e.ep));
        chk("hit_cnt", e.id, 8'(hit_cnt), 8'(e.ec));
      end
    end
  end

  // One row: inputs for the next rising edge and the outputs expected after it.
  task automatic step(input logic r, input logic c, input logic [1:0] m,
                      input logic [3:0] v, input logic [3:0] d,
                      input logic [3:0] eo, input logic [3:0] ep, input logic [7:0] ec);
    exp_t e;
    @(negedge clk);
    rst      = r;
    clear    = c;
    mode     = m;
    in_valid = v;
    in       = d;
    e.id = step_id;
    e.eo = eo;
    e.ep = ep;
    e.ec = ec;
    exp_q.push_back(e);
    step_id++;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; mode = 2'b00; in_valid = '0; in = '0;

    // Reset state and release
    step(0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // ch0, ones mode, six 1s
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h1, 4'h1, 8'h01);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h1, 4'h0, 8'h01);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h1, 4'h0, 8'h01);
    step(1, 1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // ch1, zeros mode, 0,0,0,1,0,0,0,0
    step(1, 0, 2'b01, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b01, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b01, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b01, 4'h2, 4'h2, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b01, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b01, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b01, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b01, 4'h2, 4'h0, 4'h2, 4'h2, 8'h04);
    step(1, 0, 2'b01, 4'h0, 4'h0, 4'h2, 4'h0, 8'h04);
    // live mode changes on a saturated zero run
    step(1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h04);
    step(1, 0, 2'b11, 4'h0, 4'h0, 4'h0, 4'h0, 8'h04);
    step(1, 0, 2'b10, 4'h0, 4'h0, 4'h2, 4'h0, 8'h04);
    step(1, 1, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // ch2, both mode, 1x4 then 0x4
    step(1, 0, 2'b10, 4'h4, 4'h4, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b10, 4'h4, 4'h4, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b10, 4'h4, 4'h4, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b10, 4'h4, 4'h4, 4'h4, 4'h4, 8'h10);
    step(1, 0, 2'b10, 4'h4, 4'h0, 4'h0, 4'h0, 8'h10);
    step(1, 0, 2'b10, 4'h4, 4'h0, 4'h0, 4'h0, 8'h10);
    step(1, 0, 2'b10, 4'h4, 4'h0, 4'h0, 4'h0, 8'h10);
    step(1, 0, 2'b10, 4'h4, 4'h0, 4'h4, 4'h4, 8'h20);
    step(1, 1, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // ch3, ones mode, in_valid gaps 1,0,1,0,1,0,1 then idle
    step(1, 0, 2'b00, 4'h8, 4'h8, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h0, 4'h8, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h8, 4'h8, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h0, 4'h8, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h8, 4'h8, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h0, 4'h8, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h8, 4'h8, 4'h8, 4'h8, 8'h40);
    step(1, 0, 2'b00, 4'h0, 4'h8, 4'h8, 4'h0, 8'h40);
    step(1, 1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // ch0 counter saturation: (four 1s, one 0) x5, counts 1,2,3,3,3
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] c;
      c = (k > 3) ? 8'h03 : 8'(k);
      step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, (k == 1) ? 8'h00 : ((k > 4) ? 8'h03 : 8'(k - 1)));
      step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, (k == 1) ? 8'h00 : ((k > 4) ? 8'h03 : 8'(k - 1)));
      step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, (k == 1) ? 8'h00 : ((k > 4) ? 8'h03 : 8'(k - 1)));
      step(1, 0, 2'b00, 4'h1, 4'h1, 4'h1, 4'h1, c);
      step(1, 0, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0, c);
    end
    step(1, 1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // Reset mid-run after three 1s, then one more 1: no inherited history
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // Clear after a completed run, then clear beating in_valid, then a fresh run
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h1, 4'h1, 8'h01);
    step(1, 1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    step(1, 1, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    step(1, 0, 2'b00, 4'h1, 4'h1, 4'h1, 4'h1, 8'h01);
    step(1, 0, 2'b00, 4'h0, 4'h0, 4'h1, 4'h0, 8'h01);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
